// File: rtl/hh_param_spi_loader.sv
// hh_param_spi_loader: SPI-style configuration slave writing an 8x12 neuron parameter bank.
// Frames are oversampled on clk; read data is returned on miso_o during the data phase.
module hh_param_spi_loader #(
  parameter int N_REGS = 8,
  parameter int DATA_W = 12,
  parameter logic [N_REGS*DATA_W-1:0] PARAM_RST = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic                       sclk_i,
  input  logic                       cs_n_i,
  input  logic                       mosi_i,
  output logic                       miso_o,
  output logic                       miso_oe,
  output logic [N_REGS*DATA_W-1:0]   param_flat,
  output logic                       wr_strobe,
  output logic [2:0]                 wr_addr,
  output logic                       frame_err
);
  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;
  state_t              r_state;
  logic                r_sclk_m, r_sclk_s, r_sclk_d;
  logic                r_cs_m, r_cs_s;
  logic                r_mosi_m, r_mosi_s;
  logic [3:0]          r_cnt;
  logic [DATA_W-2:0]   r_shift;
  logic [DATA_W-2:0]   r_sout;
  logic [2:0]          r_addr;
  logic                r_write, r_ovr, r_miso, r_wr_strobe, r_frame_err;
  logic [2:0]          r_wr_addr;
  logic [DATA_W-1:0]   r_regs [N_REGS];
  logic                w_rise, w_fall;
  logic [2:0]          w_addr;
  assign w_rise  = r_sclk_s & ~r_sclk_d;
  assign w_fall  = ~r_sclk_s & r_sclk_d;
  assign w_addr  = {r_shift[1:0], r_mosi_s};
  assign miso_o    = r_miso;
  assign miso_oe   = ena & ~r_cs_s;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign frame_err = r_frame_err;
  for (genvar k = 0; k < N_REGS; k++) begin : g_flat
    assign param_flat[k*DATA_W +: DATA_W] = r_regs[k];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sclk_m    <= 1'b1;
      r_sclk_s    <= 1'b1;
      r_sclk_d    <= 1'b1;
      r_cs_m      <= 1'b1;
      r_cs_s      <= 1'b1;
      r_mosi_m    <= 1'b0;
      r_mosi_s    <= 1'b0;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_sout      <= '0;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_ovr       <= 1'b0;
      r_miso      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_frame_err <= 1'b0;
      for (int k = 0; k < N_REGS; k++) r_regs[k] <= PARAM_RST[k*DATA_W +: DATA_W];
    end else begin
      r_sclk_m    <= sclk_i;
      r_sclk_s    <= r_sclk_m;
      r_sclk_d    <= r_sclk_s;
      r_cs_m      <= cs_n_i;
      r_cs_s      <= r_cs_m;
      r_mosi_m    <= mosi_i;
      r_mosi_s    <= r_mosi_m;
      r_wr_strobe <= 1'b0;
      r_frame_err <= 1'b0;
      if (!ena) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_ovr   <= 1'b0;
        r_miso  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: if (!r_cs_s) begin
            r_state <= S_CMD;
            r_cnt   <= '0;
            r_ovr   <= 1'b0;
          end
          S_CMD: if (r_cs_s) begin
            r_frame_err <= (r_cnt != 4'd0);
            r_state     <= S_IDLE;
          end else if (w_rise) begin
            r_shift <= {r_shift[DATA_W-3:0], r_mosi_s};
            r_cnt   <= r_cnt + 4'd1;
            if (r_cnt == 4'd3) begin
              r_state <= S_DATA;
              r_write <= r_shift[2];
              r_addr  <= w_addr;
              if (!r_shift[2]) begin
                r_sout <= r_regs[w_addr][DATA_W-2:0];
                r_miso <= r_regs[w_addr][DATA_W-1];
              end
            end
          end
          S_DATA: if (r_cs_s) begin
            r_frame_err <= 1'b1;
            r_state     <= S_IDLE;
            r_miso      <= 1'b0;
          end else if (w_rise) begin
            r_shift <= {r_shift[DATA_W-3:0], r_mosi_s};
            r_cnt   <= r_cnt + 4'd1;
            if (r_cnt == 4'd15) begin
              r_state <= S_DONE;
              r_miso  <= 1'b0;
              if (r_write) begin
                r_regs[r_addr] <= {r_shift, r_mosi_s};
                r_wr_addr      <= r_addr;
                r_wr_strobe    <= 1'b1;
              end
            end
          end else if (w_fall && !r_write) begin
            r_miso <= r_sout[DATA_W-2];
            r_sout <= {r_sout[DATA_W-3:0], 1'b0};
          end
          S_DONE: if (r_cs_s) begin
            r_frame_err <= r_ovr;
            r_ovr       <= 1'b0;
            r_state     <= S_IDLE;
          end else if (w_rise) begin
            r_ovr <= 1'b1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/hh_param_spi_loader.md
# hh_param_spi_loader

Serial configuration slave for the Hodgkin-Huxley neuron tile: receives SPI-style frames driven onto the dedicated input pins by the test host or external controller, writes them into an 8-entry bank of 12-bit neuron parameters (conductances, reversal potentials, stimulus current), and returns register contents on a bidirectional IO pin. It is the reader/responder for the host-side write stream. The neuron core consumes `param_flat` directly.

## Interface

- `N_REGS`, 8, number of parameter registers (address width fixed at 3 bits)
- `DATA_W`, 12, parameter width in bits
- `PARAM_RST`, 96'h0, flat reset values; entry k is `PARAM_RST[k*12 +: 12]`

- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `ena`  in  1  design selected; when low, frame logic is held idle
- `sclk_i`  in  1  serial clock from host (asynchronous to `clk`)
- `cs_n_i`  in  1  active-low frame select (asynchronous)
- `mosi_i`  in  1  host-to-block data (asynchronous)
- `miso_o`  out  1  block-to-host data
- `miso_oe`  out  1  output enable for `miso_o` pad
- `param_flat`  out  96  all registers, entry k at `[k*12 +: 12]`
- `wr_strobe`  out  1  one-cycle pulse when a register is written
- `wr_addr`  out  3  address of the last write; valid with `wr_strobe`
- `frame_err`  out  1  one-cycle pulse on a short or overlong frame

## Operation

- `sclk_i`, `cs_n_i`, `mosi_i` each pass through a 2-flop synchronizer; edge detection compares synchronized value with a third flop.
- Frame, MSB first, 16 bits, sampled on synchronized `sclk` rising edges while synchronized `cs_n` is low: bit 15 = W (1 write, 0 read), bits 14:12 = address, bits 11:0 = data.
- States: IDLE (cs_n high) -> CMD (bits 15..12 shifting) -> DATA (bits 11..0) -> DONE (16 bits seen, waiting for cs_n high) -> IDLE.
- CMD->DATA after 4th rising edge: address latched; if W=0, shift-out register loaded with `reg[addr]`.
- Read: `miso_o` presents shift-out MSB, advancing one bit per synchronized `sclk` falling edge during DATA; `miso_o` = 0 in CMD, IDLE, DONE. Read data arriving in bits 11..0 of MOSI is ignored.
- Write: on 16th rising edge with W=1, `reg[addr] <= data`, `wr_addr <= addr`, `wr_strobe` high for exactly one cycle.
- `miso_oe` = 1 whenever synchronized `cs_n` low and `ena` high, else 0.
- Short frame: cs_n rises with 1..15 bits received -> no register change, `frame_err` pulses one cycle, return to IDLE.
- Overrun: any rising edge in DONE sets an overrun flag; write already committed stays; `frame_err` pulses when cs_n rises. Further bits ignored.
- cs_n rising with 0 bits: no error.
- `ena` low: state forced to IDLE, bit counter and overrun cleared, no strobes or errors; registers retained.

## Timing

- Reset (async assert, sync deassert via design): state IDLE, counter 0, registers = `PARAM_RST`, `miso_o` 0, `miso_oe` 0, `wr_strobe` 0, `wr_addr` 0, `frame_err` 0, synchronizer flops 1 for cs_n/sclk, 0 for mosi.
- Pin-to-sample latency: 3 `clk` cycles from `sclk_i` rise to bit capture.
- `wr_strobe`/`param_flat` update: cycle after the 16th sample is captured.
- `miso_o` changes 3 cycles after `sclk_i` fall; first read bit valid 3 cycles after 4th `sclk_i` rise.
- `frame_err`: 3 cycles after `cs_n_i` rise.
- Requirement: each `sclk_i` high and low phase >= 4 `clk` periods; cs_n setup to first sclk rise >= 4 periods.
- Reset mid-frame aborts the frame immediately; no partial write.

## Test plan

- Write frame W=1, addr 3, data 0xABC (0xBABC) -> `param_flat[47:36]` = 0xABC, `wr_strobe` one cycle, `wr_addr` = 3, other entries unchanged.
- Then read addr 3 (0x3000) -> `miso_o` bits over DATA phase = 1010_1011_1100, `miso_oe` high throughout frame, no `wr_strobe`.
- Short frame: 10 bits of 0x8FFF then cs_n high -> no register change, `frame_err` single pulse.
- Overrun: 20 bits starting 0x9123 -> `param_flat[23:12]` = 0x123 after bit 16, `frame_err` pulse at cs_n rise.
- Reset mid-frame (after 8 bits) with `PARAM_RST` entry 0 = 0x055 -> registers = `PARAM_RST`, all outputs at reset values; next full frame works normally.
- `ena` low during a full write frame -> no register change, `miso_oe` 0, no strobes.
